// File: rtl/paralelo_serial_tx.sv
// Byte-to-bit serializer: MSB-first stream at clk_32f, comma idle fill, valid/ready input.
// Define PS_TX_SYNC_EN to send SYNC_BC comma symbols after every reset before user data.
module paralelo_serial_tx #(
  parameter int unsigned SYNC_BC = 4,
  parameter logic [7:0]  COMMA   = 8'hBC
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       sym_start,
  output logic       active_out
);

  if ((SYNC_BC < 32'd1) || (SYNC_BC > 32'd15)) begin : g_bad_sync_bc
    $error("paralelo_serial_tx: SYNC_BC must be in 1..15");
  end

  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       first_q, first_d;
  logic       data_q, data_d;
  logic       ready_q, ready_d;
  logic       sym_q, sym_d;
  logic       active_q, active_d;

  logic       load_s, run_load_s, accept_s;
  logic [7:0] sym_s;

`ifdef PS_TX_SYNC_EN
  localparam logic [3:0] SYNC_BC_C = 4'(SYNC_BC);

  typedef enum logic {SYNC, RUN} state_e;
  state_e     state_q, state_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;

  // Preamble FSM state and comma counter.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q  <= SYNC;
      bc_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      bc_cnt_q <= bc_cnt_d;
    end
  end
`endif

  // Symbol load decision, holding register and shift datapath.
  always_comb begin
    load_s   = first_q | (bit_cnt_q == 3'd7);
    // The registered ready lags hold_full by one edge, so hold_full also gates acceptance.
    accept_s = valid_in & ready_q & ~hold_full_q;
`ifdef PS_TX_SYNC_EN
    state_d    = state_q;
    bc_cnt_d   = bc_cnt_q;
    run_load_s = 1'b0;
    if (load_s) begin
      if (state_q == RUN) begin
        run_load_s = 1'b1;
      end else if (bc_cnt_q == SYNC_BC_C) begin
        run_load_s = 1'b1;
        state_d    = RUN;
      end else begin
        bc_cnt_d = bc_cnt_q + 4'd1;
      end
    end else begin
      run_load_s = 1'b0;
    end
`else
    run_load_s = load_s;
`endif
    sym_s  = (run_load_s & hold_full_q) ? hold_q : COMMA;
    hold_d = accept_s ? data_in : hold_q;
    if (run_load_s & hold_full_q) begin
      hold_full_d = 1'b0;
    end else if (accept_s) begin
      hold_full_d = 1'b1;
    end else begin
      hold_full_d = hold_full_q;
    end
    if (load_s) begin
      data_d    = sym_s[7];
      shreg_d   = {sym_s[6:0], 1'b0};
      bit_cnt_d = 3'd0;
    end else begin
      data_d    = shreg_q[7];
      shreg_d   = {shreg_q[6:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    ready_d  = ~hold_full_q;
    sym_d    = load_s;
    active_d = active_q | run_load_s;
    first_d  = 1'b0;
  end

  // Datapath and output registers.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      shreg_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      first_q     <= 1'b1;
      data_q      <= 1'b0;
      ready_q     <= 1'b0;
      sym_q       <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      first_q     <= first_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      sym_q       <= sym_d;
      active_q    <= active_d;
    end
  end

  assign data_out   = data_q;
  assign ready_out  = ready_q;
  assign sym_start  = sym_q;
  assign active_out = active_q;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Scoreboard bench for paralelo_serial_tx: stimulus queues expected symbols, a monitor
// reassembles each 8-bit symbol from data_out and compares it (comma when nothing is due).
`timescale 1ns/1ps
module tb_paralelo_serial_tx;

`ifdef PS_TX_SYNC_EN
  localparam int PRE = 4;
`else
  localparam int PRE = 0;
`endif
  localparam logic [7:0] COMMA   = 8'hBC;
  localparam int         ACT_CYC = 8 * PRE + 1;

  logic       clk_32f  = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] data_in  = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, data_out, sym_start, active_out;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  int         idx_q[$];
  logic [7:0] val_q[$];

  paralelo_serial_tx #(.SYNC_BC(4), .COMMA(8'hBC)) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .sym_start (sym_start),
    .active_out(active_out)
  );

  always #5 clk_32f = ~clk_32f;

  // Edge number since reset release (edge 1 is the first rising edge with reset low).
  always @(posedge clk_32f) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer one byte, holding valid for a single edge; the expected symbol index is
  // the first boundary at or after the accept edge + 1, but not inside the preamble.
  task automatic send(input logic [7:0] b, output int k);
    int t;
    int guard;
    guard = 0;
    k = -1;
    while (ready_out !== 1'b1 && guard < 200) begin
      @(negedge clk_32f);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready_out=%b, required 1 for byte %02h", ready_out, b);
    end else begin
      t = cyc + 1;
      k = (t + 7) / 8;
      if (k < PRE) k = PRE;
      idx_q.push_back(k);
      val_q.push_back(b);
      data_in  = b;
      valid_in = 1'b1;
      @(negedge clk_32f);
      valid_in = 1'b0;
      data_in  = 8'h00;
      @(negedge clk_32f);
    end
  endtask

  // Monitor: frame check on every cycle, symbol compare every 8th cycle.
  initial begin : monitor
    logic [7:0] acc;
    logic [7:0] exp_sym;
    int         k;
    acc = 8'h00;
    forever begin
      @(negedge clk_32f);
      if (reset || cyc == 0) begin
        acc = 8'h00;
      end else begin
        chk("sym_start", 32'(sym_start), 32'(((cyc - 1) % 8) == 0));
        chk("active_out", 32'(active_out), 32'(cyc >= ACT_CYC));
        acc = {acc[6:0], data_out};
        if (((cyc - 1) % 8) == 7) begin
          k = (cyc - 1) / 8;
          while (idx_q.size() > 0 && idx_q[0] < k) begin
            checks++;
            errors++;
            $display("FAIL byte_missing: byte %02h due in symbol %0d not seen by symbol %0d",
                     val_q[0], idx_q[0], k);
            void'(idx_q.pop_front());
            void'(val_q.pop_front());
          end
          if (idx_q.size() > 0 && idx_q[0] == k) begin
            exp_sym = val_q.pop_front();
            void'(idx_q.pop_front());
          end else begin
            exp_sym = COMMA;
          end
          chk($sformatf("symbol_%0d", k), 32'(acc), 32'(exp_sym));
        end
      end
    end
  end

  initial begin : stimulus
    int k;
    int first_k;
    int last_k;
    int load_edge;
    logic [7:0] b2b [6];
    b2b = '{8'h15, 8'hDD, 8'h45, 8'hAA, 8'hBC, 8'h13};

    repeat (3) @(negedge clk_32f);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_ready_out", 32'(ready_out), 32'd0);
    chk("rst_sym_start", 32'(sym_start), 32'd0);
    chk("rst_active_out", 32'(active_out), 32'd0);
    reset = 1'b0;

    // Early byte: accepted at edge 2, held until the first run-state boundary.
    send(8'hF2, k);
    chk("early_accept_symbol", 32'(k), 32'((PRE > 1) ? PRE : 1));
    chk("ready_low_after_accept", 32'(ready_out), 32'd0);
    load_edge = 8 * k + 1;
    while (cyc < load_edge) @(negedge clk_32f);
    chk("ready_low_at_load", 32'(ready_out), 32'd0);
    @(negedge clk_32f);
    chk("ready_high_after_load", 32'(ready_out), 32'd1);

    repeat (20) @(negedge clk_32f);

    // Back-to-back bytes, including a user byte equal to the comma.
    first_k = -1;
    last_k  = -1;
    foreach (b2b[i]) begin
      send(b2b[i], k);
      if (i == 0) first_k = k;
      last_k = k;
    end
    chk("b2b_no_gap", 32'(last_k - first_k), 32'd5);
    repeat (24) @(negedge clk_32f);

    // Reset with 0x45 partly shifted and 0xAA waiting in hold.
    send(8'h45, k);
    send(8'hAA, k);
    reset = 1'b1;
    idx_q.delete();
    val_q.delete();
    @(negedge clk_32f);
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_ready_out", 32'(ready_out), 32'd0);
    chk("midrst_sym_start", 32'(sym_start), 32'd0);
    chk("midrst_active_out", 32'(active_out), 32'd0);
    @(negedge clk_32f);
    reset = 1'b0;
    repeat (8 * (PRE + 3)) @(negedge clk_32f);

    chk("scoreboard_drained", 32'(idx_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
